// File: rtl/fifo_read_stream.sv
// Read-domain drain stage: issues FIFO reads under a 2-slot credit rule and presents a valid/ready stream.
// Optional delivered-word counter enabled by defining FIFO_READ_STREAM_COUNT_EN.
module fifo_read_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                  state_q;
  logic                  inflight_q;
  logic                  run_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic       pop;
  logic [2:0] credit_sum;

  assign pop     = valid_q & m_ready;
  assign m_valid = valid_q;
  assign m_data  = head_q;

  // Words held plus the word landing next cycle, minus the one leaving now, must leave room.
  assign credit_sum = 3'(state_q) + 3'(inflight_q) - 3'(pop);
  assign fifo_rd_en = run_q & ~fifo_empty & (credit_sum < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_q <= fifo_rd_en;
      case (state_q)
        EMPTY: begin
          if (inflight_q) begin
            state_q <= ONE;
            head_q  <= fifo_data;
            valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (inflight_q && pop) begin
            head_q <= fifo_data;
          end else if (inflight_q) begin
            state_q <= TWO;
            tail_q  <= fifo_data;
          end else if (pop) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            head_q <= tail_q;
            if (inflight_q) begin
              tail_q <= fifo_data;
            end else begin
              state_q <= ONE;
            end
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_READ_STREAM_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

  assign word_count = count_q;
`else
  assign word_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_stream.sv
// Directed bench for fifo_read_stream: behavioural FIFO read port, delivery log, per-scenario tasks.
module tb_fifo_read_stream;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] word_count;

  int checks_total;
  int checks_pass;

  fifo_read_stream #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: one-cycle registered read, emptied by the shared reset.
  logic [7:0] mem [0:4095];
  int wr_cnt;
  int rd_cnt;
  int underflow_n;

  initial begin
    wr_cnt = 0;
  end

  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt    <= wr_cnt;
      fifo_data <= 8'h00;
    end else if (fifo_rd_en) begin
      if (fifo_empty) underflow_n <= underflow_n + 1;
      fifo_data <= mem[rd_cnt % 4096];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  initial underflow_n = 0;

  // Delivery log and protocol monitors.
  logic [7:0] got [0:4095];
  int   got_n;
  int   stab_err;
  int   illegal_n;
  logic hold_valid;
  logic [7:0] hold_data;

  initial begin
    got_n     = 0;
    stab_err  = 0;
    illegal_n = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        got[got_n % 4096] <= m_data;
        got_n <= got_n + 1;
      end
      if (hold_valid && (!m_valid || m_data !== hold_data)) stab_err <= stab_err + 1;
      hold_valid <= m_valid && !m_ready;
      hold_data  <= m_data;
      if (int'(dut.state_q) == 2 && dut.inflight_q && !(m_valid && m_ready))
        illegal_n <= illegal_n + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_cnt % 4096] = d;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic test_reset;
    int base_g;
    int exp_wc;
    logic [7:0] exp_w;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks_total++;
    if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else checks_pass++;
    checks_total++;
    if (m_data !== 8'h00) $display("FAIL reset_m_data got=%h exp=00", m_data); else checks_pass++;
    checks_total++;
    if (word_count !== 16'd0) $display("FAIL reset_word_count got=%0d exp=0", word_count); else checks_pass++;
    checks_total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); else checks_pass++;
    base_g = got_n;
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    m_ready = 1'b1;
    #1;
    checks_total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL first_clock_rd_en got=%b exp=0", fifo_rd_en); else checks_pass++;
    @(negedge clk);
    #1;
    checks_total++;
    if (fifo_rd_en !== 1'b1) $display("FAIL second_clock_rd_en got=%b exp=1", fifo_rd_en); else checks_pass++;
    @(negedge clk);
    #1;
    checks_total++;
    if (m_valid !== 1'b0) $display("FAIL latency_n1_valid got=%b exp=0", m_valid); else checks_pass++;
    @(negedge clk);
    #1;
    checks_total++;
    if (m_valid !== 1'b1 || m_data !== 8'h11)
      $display("FAIL latency_n2 got valid=%b data=%h exp valid=1 data=11", m_valid, m_data);
    else checks_pass++;
    for (int k = 0; k < 20 && (got_n - base_g) < 3; k++) @(negedge clk);
    m_ready = 1'b0;
    checks_total++;
    if (got_n - base_g !== 3) $display("FAIL reset_word_total got=%0d exp=3", got_n - base_g); else checks_pass++;
    for (int i = 0; i < 3; i++) begin
      exp_w = 8'h11 * 8'(i + 1);
      checks_total++;
      if (got[(base_g + i) % 4096] !== exp_w)
        $display("FAIL reset_order[%0d] got=%h exp=%h", i, got[(base_g + i) % 4096], exp_w);
      else checks_pass++;
    end
`ifdef FIFO_READ_STREAM_COUNT_EN
    exp_wc = 3;
`else
    exp_wc = 0;
`endif
    #1;
    checks_total++;
    if (word_count !== 16'(exp_wc)) $display("FAIL reset_word_count_after got=%0d exp=%0d", word_count, exp_wc);
    else checks_pass++;
    $display("test_reset done: delivered %0d words", got_n - base_g);
  endtask

  task automatic test_stream;
    int base_g;
    int base_r;
    int rd_miss;
    int vld_miss;
    int bad;
    int cnt65;
    int cnt66;
    logic v66;
    @(negedge clk);
    base_g = got_n;
    base_r = rd_cnt;
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++) push(8'(8'h40 + i));
    rd_miss = 0;
    vld_miss = 0;
    cnt65 = 0;
    cnt66 = 0;
    v66 = 1'b1;
    #1;
    if (fifo_rd_en !== 1'b1) rd_miss++;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      #1;
      if (k <= 63 && fifo_rd_en !== 1'b1) rd_miss++;
      if (k >= 2 && k <= 65 && m_valid !== 1'b1) vld_miss++;
      if (k == 65) cnt65 = got_n - base_g;
      if (k == 66) begin
        cnt66 = got_n - base_g;
        v66 = m_valid;
      end
    end
    checks_total++;
    if (rd_miss != 0) $display("FAIL stream_rd_en_gaps got=%0d exp=0", rd_miss); else checks_pass++;
    checks_total++;
    if (vld_miss != 0) $display("FAIL stream_valid_gaps got=%0d exp=0", vld_miss); else checks_pass++;
    checks_total++;
    if (cnt65 != 63 || cnt66 != 64)
      $display("FAIL stream_66_cycles got=%0d/%0d exp=63/64", cnt65, cnt66);
    else checks_pass++;
    checks_total++;
    if (v66 !== 1'b0) $display("FAIL stream_idle_valid got=%b exp=0", v66); else checks_pass++;
    checks_total++;
    if (rd_cnt - base_r != 64) $display("FAIL stream_reads got=%0d exp=64", rd_cnt - base_r); else checks_pass++;
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (got[(base_g + i) % 4096] !== 8'(8'h40 + i)) bad++;
    checks_total++;
    if (bad != 0) $display("FAIL stream_data got=%0d bad words exp=0", bad); else checks_pass++;
    m_ready = 1'b0;
    $display("test_stream done: delivered %0d words", cnt66);
  endtask

  task automatic test_backpressure;
    int base_g;
    int base_r;
    int bad;
    @(negedge clk);
    base_g = got_n;
    base_r = rd_cnt;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    repeat (6) @(negedge clk);
    #1;
    checks_total++;
    if (rd_cnt - base_r != 2) $display("FAIL bp_reads got=%0d exp=2", rd_cnt - base_r); else checks_pass++;
    checks_total++;
    if (int'(dut.state_q) != 2) $display("FAIL bp_occ got=%0d exp=2", int'(dut.state_q)); else checks_pass++;
    checks_total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en got=%b exp=0", fifo_rd_en); else checks_pass++;
    checks_total++;
    if (m_valid !== 1'b1 || m_data !== 8'hA0)
      $display("FAIL bp_head got valid=%b data=%h exp valid=1 data=a0", m_valid, m_data);
    else checks_pass++;
    m_ready = 1'b1;
    for (int k = 0; k < 20 && (got_n - base_g) < 4; k++) @(negedge clk);
    m_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (got[(base_g + i) % 4096] !== 8'(8'hA0 + i)) bad++;
    checks_total++;
    if (got_n - base_g != 4 || bad != 0)
      $display("FAIL bp_drain got=%0d words %0d bad exp=4 words 0 bad", got_n - base_g, bad);
    else checks_pass++;
    $display("test_backpressure done: delivered %0d words", got_n - base_g);
  endtask

  task automatic test_drain_inflight;
    int base_g;
    int base_r;
    @(negedge clk);
    base_g = got_n;
    base_r = rd_cnt;
    m_ready = 1'b1;
    push(8'h5A);
    #1;
    checks_total++;
    if (fifo_rd_en !== 1'b1) $display("FAIL drain_rd_en_k0 got=%b exp=1", fifo_rd_en); else checks_pass++;
    @(negedge clk);
    #1;
    checks_total++;
    if (fifo_rd_en !== 1'b0) $display("FAIL drain_empty_rd_en got=%b exp=0", fifo_rd_en); else checks_pass++;
    @(negedge clk);
    #1;
    checks_total++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A)
      $display("FAIL drain_last_word got valid=%b data=%h exp valid=1 data=5a", m_valid, m_data);
    else checks_pass++;
    repeat (3) @(negedge clk);
    #1;
    checks_total++;
    if (m_valid !== 1'b0 || rd_cnt - base_r != 1 || got_n - base_g != 1 || underflow_n != 0)
      $display("FAIL drain_idle got valid=%b reads=%0d words=%0d underflow=%0d exp 0/1/1/0",
               m_valid, rd_cnt - base_r, got_n - base_g, underflow_n);
    else checks_pass++;
    m_ready = 1'b0;
    $display("test_drain_inflight done: delivered %0d words", got_n - base_g);
  endtask

  task automatic test_random_ready;
    int base_g;
    int bad;
    int stab0;
    int ill0;
    int exp_wc;
    logic [15:0] lfsr;
    @(negedge clk);
    base_g = got_n;
    stab0 = stab_err;
    ill0 = illegal_n;
    lfsr = 16'hACE1;
    for (int i = 0; i < 1000; i++) push(8'(i * 7 + 3));
    for (int k = 0; k < 6000 && (got_n - base_g) < 1000; k++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      m_ready = lfsr[0];
      @(negedge clk);
    end
    m_ready = 1'b0;
    checks_total++;
    if (got_n - base_g != 1000) $display("FAIL rand_count got=%0d exp=1000", got_n - base_g); else checks_pass++;
    bad = 0;
    for (int i = 0; i < 1000; i++)
      if (got[(base_g + i) % 4096] !== 8'(i * 7 + 3)) bad++;
    checks_total++;
    if (bad != 0) $display("FAIL rand_scoreboard got=%0d bad words exp=0", bad); else checks_pass++;
    checks_total++;
    if (illegal_n != ill0) $display("FAIL rand_illegal_two got=%0d exp=0", illegal_n - ill0); else checks_pass++;
    checks_total++;
    if (stab_err != stab0) $display("FAIL rand_stability got=%0d exp=0", stab_err - stab0); else checks_pass++;
`ifdef FIFO_READ_STREAM_COUNT_EN
    exp_wc = 1072;
`else
    exp_wc = 0;
`endif
    #1;
    checks_total++;
    if (word_count !== 16'(exp_wc)) $display("FAIL rand_word_count got=%0d exp=%0d", word_count, exp_wc);
    else checks_pass++;
    $display("test_random_ready done: delivered %0d words", got_n - base_g);
  endtask

  task automatic test_reset_mid;
    int base_g;
    @(negedge clk);
    m_ready = 1'b0;
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    repeat (5) @(negedge clk);
    #1;
    checks_total++;
    if (int'(dut.state_q) != 2) $display("FAIL mid_occ_before got=%0d exp=2", int'(dut.state_q)); else checks_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || word_count !== 16'd0)
      $display("FAIL mid_async_clear got valid=%b data=%h count=%0d exp 0/00/0", m_valid, m_data, word_count);
    else checks_pass++;
    base_g = got_n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(8'hD1);
    push(8'hD2);
    m_ready = 1'b1;
    for (int k = 0; k < 20 && (got_n - base_g) < 2; k++) @(negedge clk);
    m_ready = 1'b0;
    checks_total++;
    if (got_n - base_g != 2 || got[base_g % 4096] !== 8'hD1 || got[(base_g + 1) % 4096] !== 8'hD2)
      $display("FAIL mid_post_reset got n=%0d first=%h second=%h exp n=2 d1 d2",
               got_n - base_g, got[base_g % 4096], got[(base_g + 1) % 4096]);
    else checks_pass++;
    $display("test_reset_mid done: delivered %0d words", got_n - base_g);
  endtask

  initial begin
    checks_total = 0;
    checks_pass  = 0;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain_inflight();
    test_random_ready();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
